xgmii_pattern_gen_chk: RTL and testbench

Self-checking XGMII traffic generator and checker for PHY loopback bring-up and regression, in synthesizable form. The TX side drives xgmii_txd/xgmii_txc into the PHY. The RX side waits for rx_status, aligns to the looped-back stream, verifies it word by word, and reports pass/fail plus error counts. Generalises the fixed 64-bit six-pattern loop to any lane width and to selectable pattern modes, with alignment search and a timeout.

---
 rtl/xgmii_pattern_gen_chk.sv | 218 +++++++++++++++++++++
 tb/tb_xgmii_pattern_gen_chk.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_pattern_gen_chk.sv
// xgmii_pattern_gen_chk
//   XGMII loopback traffic generator and checker for PHY bring-up.
//   The TX side emits a selectable pattern while a run is active. The RX side
//   waits for link, aligns to the looped-back stream in a single cycle, then
//   checks it word by word until PASS_COUNT consecutive matches (pass) or
//   TIMEOUT_CYCLES elapse from start (fail).
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start               one-cycle pulse, (re)starts a run and clears status
//   mode                0 fixed table, 1 incrementing bytes, 2 idle, 3 as 0
//   xgmii_txd/txc       generated TX word
//   xgmii_rxd/rxc       looped-back RX word
//   rx_status           PHY link status
//   busy, pass, fail    run state and sticky result
//   error_count         saturating CHECK mismatch count
//   match_count         current consecutive-match run length (saturating)
module xgmii_pattern_gen_chk #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int PASS_COUNT     = 256,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int ERR_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic [DATA_WIDTH-1:0] xgmii_txd,
    output logic [CTRL_WIDTH-1:0] xgmii_txc,
    input  logic [DATA_WIDTH-1:0] xgmii_rxd,
    input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
    input  logic                  rx_status,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [15:0]           match_count
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] SEARCH    = 3'd2;
    localparam logic [2:0] CHECK     = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SEQ_STEP  = 8'(CTRL_WIDTH);

    logic [2:0]    state;
    logic [1:0]    mode_r;
    logic [2:0]    gen_idx;
    logic [7:0]    gen_seq;
    logic [2:0]    chk_idx;
    logic [7:0]    chk_seq;
    logic [TW-1:0] timer;

    function automatic logic [DATA_WIDTH-1:0] rep(input logic [7:0] b);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < CTRL_WIDTH; k++) w[8*k +: 8] = b;
        return w;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ramp(input logic [7:0] s);
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < CTRL_WIDTH; k++) w[8*k +: 8] = s + 8'(k);
        return w;
    endfunction

    function automatic logic [7:0] tab(input logic [2:0] i);
        case (i)
            3'd0:    return 8'hFF;
            3'd1:    return 8'h00;
            3'd2:    return 8'h55;
            3'd3:    return 8'hAA;
            3'd4:    return 8'hFE;
            default: return 8'h07;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'd5) ? 3'd0 : i + 3'd1;
    endfunction

    assign busy = (state == WAIT_LOCK) || (state == SEARCH) || (state == CHECK);

    // Generator: the registered word reflects the state of the previous cycle.
    always_ff @(posedge clk) begin
        if (rst || start || !busy) begin
            xgmii_txd <= rep(8'h07);
            xgmii_txc <= '1;
            gen_idx   <= '0;
            gen_seq   <= '0;
        end else begin
            case (mode_r)
                2'd1: begin
                    xgmii_txd <= ramp(gen_seq);
                    xgmii_txc <= '0;
                    gen_seq   <= gen_seq + SEQ_STEP;
                end
                2'd2: begin
                    xgmii_txd <= rep(8'h07);
                    xgmii_txc <= '1;
                end
                default: begin
                    xgmii_txd <= rep(tab(gen_idx));
                    xgmii_txc <= '0;
                    gen_idx   <= next_idx(gen_idx);
                end
            endcase
        end
    end

    // Alignment search and checker replica comparison.
    logic                  tab_hit;
    logic [2:0]            tab_next;
    logic                  search_hit;
    logic [DATA_WIDTH-1:0] exp_d;
    logic [CTRL_WIDTH-1:0] exp_c;
    logic                  chk_match;
    logic                  pass_hit;

    always_comb begin
        tab_hit  = 1'b0;
        tab_next = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (xgmii_rxd == rep(tab(3'(k)))) begin
                tab_hit  = 1'b1;
                tab_next = next_idx(3'(k));
            end
        end
        case (mode_r)
            2'd1:    search_hit = (xgmii_rxc == '0) && (xgmii_rxd == ramp(xgmii_rxd[7:0]));
            2'd2:    search_hit = (xgmii_rxc == '1) && (xgmii_rxd == rep(8'h07));
            default: search_hit = (xgmii_rxc == '0) && tab_hit;
        endcase
        case (mode_r)
            2'd1: begin
                exp_d = ramp(chk_seq);
                exp_c = '0;
            end
            2'd2: begin
                exp_d = rep(8'h07);
                exp_c = '1;
            end
            default: begin
                exp_d = rep(tab(chk_idx));
                exp_c = '0;
            end
        endcase
        chk_match = (xgmii_rxd == exp_d) && (xgmii_rxc == exp_c);
        pass_hit  = (state == CHECK) && rx_status && chk_match &&
                    (match_count == 16'(PASS_COUNT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_r      <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            error_count <= '0;
            match_count <= '0;
            timer       <= '0;
            chk_idx     <= '0;
            chk_seq     <= '0;
        end else if (start) begin
            state       <= WAIT_LOCK;
            mode_r      <= (mode == 2'd3) ? 2'd0 : mode;
            pass        <= 1'b0;
            fail        <= 1'b0;
            error_count <= '0;
            match_count <= '0;
            timer       <= '0;
        end else begin
            if (busy) timer <= timer + 1'b1;
            case (state)
                WAIT_LOCK: if (rx_status) state <= SEARCH;
                SEARCH: begin
                    if (!rx_status) begin
                        state       <= WAIT_LOCK;
                        match_count <= '0;
                    end else if (search_hit) begin
                        state   <= CHECK;
                        chk_idx <= tab_next;
                        chk_seq <= xgmii_rxd[7:0] + SEQ_STEP;
                    end
                end
                CHECK: begin
                    if (!rx_status) begin
                        state       <= WAIT_LOCK;
                        match_count <= '0;
                    end else if (chk_match) begin
                        if (match_count != '1) match_count <= match_count + 1'b1;
                        chk_idx <= next_idx(chk_idx);
                        chk_seq <= chk_seq + SEQ_STEP;
                        if (pass_hit) begin
                            pass  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        if (error_count != '1) error_count <= error_count + 1'b1;
                        match_count <= '0;
                        state       <= SEARCH;
                    end
                end
                default: ;
            endcase
            // Timeout overrides the state update above unless pass lands on the same cycle.
            if (busy && !pass_hit && (timer == TW'(TIMEOUT_CYCLES - 1))) begin
                fail  <= 1'b1;
                state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_xgmii_pattern_gen_chk.sv
// Bench for xgmii_pattern_gen_chk: a 64-bit instance (PASS_COUNT=16,
// TIMEOUT_CYCLES=100) with a 3-cycle loopback that can corrupt a byte or drop
// link, and a 32-bit instance (PASS_COUNT=80) for the incrementing pattern.
module tb_xgmii_pattern_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    localparam logic [63:0] IDLE64 = 64'h0707_0707_0707_0707;
    localparam logic [31:0] IDLE32 = 32'h0707_0707;

    // ---------------- 64-bit instance ----------------
    logic        start0 = 1'b0;
    logic [1:0]  mode0  = 2'd0;
    logic [63:0] txd0, rxd0;
    logic [7:0]  txc0, rxc0;
    logic        rxs0, busy0, pass0, fail0;
    logic [15:0] err0, mcnt0;

    int   cyc = 0;
    int   corrupt_at = -1;
    int   drop_at = -1;
    logic link_en = 1'b1;

    logic [63:0] d1 = IDLE64, d2 = IDLE64, d3 = IDLE64;
    logic [7:0]  c1 = 8'hFF, c2 = 8'hFF, c3 = 8'hFF;

    always @(posedge clk) begin
        d1 <= txd0; d2 <= d1; d3 <= d2;
        c1 <= txc0; c2 <= c1; c3 <= c2;
        if (start0) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always_comb begin
        rxd0 = d3;
        if (corrupt_at >= 0 && cyc == corrupt_at) rxd0 = d3 ^ 64'h0000_0000_0000_0100;
        rxc0 = c3;
        rxs0 = link_en && !(drop_at >= 0 && cyc >= drop_at && cyc < drop_at + 2);
    end

    xgmii_pattern_gen_chk #(
        .DATA_WIDTH(64), .PASS_COUNT(16), .TIMEOUT_CYCLES(100), .ERR_WIDTH(16)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0),
        .xgmii_txd(txd0), .xgmii_txc(txc0), .xgmii_rxd(rxd0), .xgmii_rxc(rxc0),
        .rx_status(rxs0), .busy(busy0), .pass(pass0), .fail(fail0),
        .error_count(err0), .match_count(mcnt0)
    );

    // ---------------- 32-bit instance ----------------
    logic        start1 = 1'b0;
    logic [1:0]  mode1  = 2'd0;
    logic [31:0] txd1, e1 = IDLE32, e2 = IDLE32, e3 = IDLE32;
    logic [3:0]  txc1, f1 = 4'hF, f2 = 4'hF, f3 = 4'hF;
    logic        busy1, pass1, fail1;
    logic [15:0] err1, mcnt1;

    always @(posedge clk) begin
        e1 <= txd1; e2 <= e1; e3 <= e2;
        f1 <= txc1; f2 <= f1; f3 <= f2;
    end

    xgmii_pattern_gen_chk #(
        .DATA_WIDTH(32), .PASS_COUNT(80), .TIMEOUT_CYCLES(1000), .ERR_WIDTH(16)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1),
        .xgmii_txd(txd1), .xgmii_txc(txc1), .xgmii_rxd(e3), .xgmii_rxc(f3),
        .rx_status(1'b1), .busy(busy1), .pass(pass1), .fail(fail1),
        .error_count(err1), .match_count(mcnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] mode;
        int         corrupt_at;
        int         drop_at;
        logic       link;
        int         cycles;
        logic       pass;
        logic       fail;
        int         err;
        int         match;
    } vec_t;

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = '{"m0_clean",   2'd0, -1, -1, 1'b1,  21, 1'b1, 1'b0, 0, 16};
        vecs[1] = '{"m2_idle",    2'd2, -1, -1, 1'b1,  18, 1'b1, 1'b0, 0, 16};
        vecs[2] = '{"m3_as_m0",   2'd3, -1, -1, 1'b1,  21, 1'b1, 1'b0, 0, 16};
        vecs[3] = '{"m0_corrupt", 2'd0, 10, -1, 1'b1,  28, 1'b1, 1'b0, 1, 16};
        vecs[4] = '{"m0_drop",    2'd0, -1, 10, 1'b1,  30, 1'b1, 1'b0, 0, 16};
        vecs[5] = '{"timeout",    2'd0, -1, -1, 1'b0, 100, 1'b0, 1'b1, 0, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd",   txd0,  IDLE64);
        chk("rst_txc",   txc0,  8'hFF);
        chk("rst_busy",  busy0, 0);
        chk("rst_pass",  pass0, 0);
        chk("rst_fail",  fail0, 0);
        chk("rst_err",   err0,  0);
        chk("rst_match", mcnt0, 0);

        for (int v = 0; v < 6; v++) begin
            corrupt_at = vecs[v].corrupt_at;
            drop_at    = vecs[v].drop_at;
            link_en    = vecs[v].link;
            repeat (10) @(negedge clk);
            mode0  = vecs[v].mode;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            mode0  = 2'd1;
            chk({vecs[v].name, "_busy0"},  busy0, 1);
            chk({vecs[v].name, "_clr_p"},  pass0, 0);
            chk({vecs[v].name, "_clr_e"},  err0,  0);
            n = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                n++;
                if (pass0 || fail0) break;
            end
            chk({vecs[v].name, "_cycles"}, n,     vecs[v].cycles);
            chk({vecs[v].name, "_pass"},   pass0, vecs[v].pass);
            chk({vecs[v].name, "_fail"},   fail0, vecs[v].fail);
            chk({vecs[v].name, "_err"},    err0,  vecs[v].err);
            chk({vecs[v].name, "_match"},  mcnt0, vecs[v].match);
            repeat (2) @(negedge clk);
            chk({vecs[v].name, "_busy"},   busy0, 0);
            chk({vecs[v].name, "_txd"},    txd0,  IDLE64);
            chk({vecs[v].name, "_txc"},    txc0,  8'hFF);
            chk({vecs[v].name, "_hold"},   pass0, vecs[v].pass);
        end

        // Reset in the middle of a run after an error, with start asserted too.
        corrupt_at = 6;
        drop_at    = -1;
        link_en    = 1'b1;
        repeat (10) @(negedge clk);
        mode0  = 2'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_err", err0, 1);
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        chk("mr_txd",   txd0,  IDLE64);
        chk("mr_txc",   txc0,  8'hFF);
        chk("mr_busy",  busy0, 0);
        chk("mr_pass",  pass0, 0);
        chk("mr_fail",  fail0, 0);
        chk("mr_err",   err0,  0);
        chk("mr_match", mcnt0, 0);
        rst    = 1'b0;
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_idle_busy", busy0, 0);
        chk("mr_idle_txd",  txd0,  IDLE64);

        // Incrementing pattern on the 32-bit instance, including the 0xFF -> 0x00 wrap.
        mode1  = 2'd1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        mode1  = 2'd0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (n == 1)  chk("m1_w1",   txd1, 32'h0302_0100);
            if (n == 1)  chk("m1_txc",  txc1, 4'h0);
            if (n == 2)  chk("m1_w2",   txd1, 32'h0706_0504);
            if (n == 64) chk("m1_wtop", txd1, 32'hFFFE_FDFC);
            if (n == 65) chk("m1_wrap", txd1, 32'h0302_0100);
            if (pass1 || fail1) break;
        end
        chk("m1_cycles", n,     85);
        chk("m1_pass",   pass1, 1);
        chk("m1_fail",   fail1, 0);
        chk("m1_err",    err1,  0);
        chk("m1_match",  mcnt1, 80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
